// File: rtl/pipeline_pkg.sv
// Shared types for the RV32 pipeline: fetch FSM states and the IF/ID bundle.
package pipeline_pkg;

    localparam int PKG_XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_t;

    typedef struct packed {
        logic                valid;
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] pc4;
        logic [31:0]         inst;
    } if_id_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry buffer holding a fetched instruction and its PC while ID stalls.
module if_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [31:0]     data_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            full_o,
    output logic [31:0]     data_o,
    output logic [XLEN-1:0] pc_o
);

    logic            full_q;
    logic [31:0]     data_q;
    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            pc_q   <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
            data_q <= data_i;
            pc_q   <= pc_i;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, runs a single-outstanding imem handshake,
// and drives the IF/ID register under hazard stall/flush control.
module if_fetch_stage
    import pipeline_pkg::*;
#(
    parameter int              XLEN     = PKG_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hz_stall,
    input  logic            hz_flush,
    input  logic [XLEN-1:0] ex_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [31:0]     if_id_inst
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    if_id_t          if_id_q;

    logic            req_fire;
    logic            rsp_take;
    logic            hold_rel;
    logic            skid_load;
    logic            skid_clr;
    logic            skid_full;
    logic [31:0]     skid_data;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] flush_pc;
    logic            busy_after;

    // Request depends only on state and reset, never on hazard inputs.
    assign imem_req_valid = rst_n & (state_q == S_REQ);
    assign imem_req_addr  = pc_q;

    assign req_fire  = imem_req_valid & imem_req_ready;
    assign rsp_take  = (state_q == S_WAIT) & imem_rsp_valid;
    assign hold_rel  = (state_q == S_HOLD) & skid_full & ~hz_stall;
    assign skid_load = rsp_take & hz_stall & ~hz_flush;
    assign skid_clr  = hz_flush | hold_rel;
    assign pc_inc    = pc_q + XLEN'(4);
    assign flush_pc  = ex_target & ~XLEN'(3);

    // A flushed request still owes us a response that must be swallowed.
    assign busy_after = req_fire
                      | (((state_q == S_WAIT) | (state_q == S_DROP))
                         & ~imem_rsp_valid);

    if_skid_buf #(
        .XLEN(XLEN)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (skid_load),
        .clear_i(skid_clr),
        .data_i (imem_rsp_data),
        .pc_i   (pc_q),
        .full_o (skid_full),
        .data_o (skid_data),
        .pc_o   (skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            if_id_q <= '{1'b0, '0, '0, NOP_INST};
        end else if (hz_flush) begin
            state_q       <= busy_after ? S_DROP : S_REQ;
            pc_q          <= flush_pc;
            if_id_q.valid <= 1'b0;
            if_id_q.inst  <= NOP_INST;
        end else begin
            unique case (state_q)
                S_REQ:   if (req_fire) state_q <= S_WAIT;
                S_WAIT:  if (imem_rsp_valid)
                             state_q <= hz_stall ? S_HOLD : S_REQ;
                S_HOLD:  if (hold_rel) state_q <= S_REQ;
                S_DROP:  if (imem_rsp_valid) state_q <= S_REQ;
                default: state_q <= S_REQ;
            endcase
            if (rsp_take && !hz_stall) begin
                if_id_q <= '{1'b1, pc_q, pc_inc, imem_rsp_data};
                pc_q    <= pc_inc;
            end else if (hold_rel) begin
                if_id_q <= '{1'b1, skid_pc, skid_pc + XLEN'(4), skid_data};
                pc_q    <= pc_inc;
            end else if (!hz_stall) begin
                if_id_q.valid <= 1'b0;
                if_id_q.inst  <= NOP_INST;
            end
        end
    end

    assign if_id_valid = if_id_q.valid;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_inst  = if_id_q.inst;

`ifndef SYNTHESIS
    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (state_q == S_WAIT || state_q == S_DROP));
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random hazards against a PC-stream model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hz_stall, hz_flush;
    logic [31:0] ex_target;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_pc4, if_id_inst;

    always #5 clk = ~clk;

    if_fetch_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hz_stall      (hz_stall),
        .hz_flush      (hz_flush),
        .ex_target     (ex_target),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_inst    (if_id_inst)
    );

    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, nloads = 0, lat = 1, cnt = 0;
    bit          pend = 0, loaded = 0;
    logic [31:0] paddr, exp_pc;
    logic        last_req_v;
    logic [31:0] last_req_a;
    logic [31:0] ovr [logic [31:0]];

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One clock: memory model drives rsp, outputs sampled at negedge and after the edge.
    task automatic tick();
        logic        pv, pf, ps, prdy;
        logic [31:0] ppc, ppc4, pinst, ptgt;
        imem_rsp_valid = pend && cnt == 0;
        imem_rsp_data  = imem_rsp_valid ? memf(paddr) : 32'hDEAD_BEEF;
        @(negedge clk);
        pv = if_id_valid; ppc = if_id_pc; ppc4 = if_id_pc4;
        pinst = if_id_inst;
        last_req_v = imem_req_valid; last_req_a = imem_req_addr;
        pf = hz_flush; ps = hz_stall; prdy = imem_req_ready;
        ptgt = ex_target;
        @(posedge clk);
        #1;
        cyc++;
        loaded = 0;
        if (imem_rsp_valid) pend = 0;
        else if (pend && cnt > 0) cnt--;
        if (last_req_v && prdy) begin
            pend = 1; paddr = last_req_a; cnt = lat - 1;
        end
        imem_rsp_valid = 1'b0;
        if (last_req_v) chk("req_align", {30'b0, last_req_a[1:0]}, 32'h0);
        if (pf) begin
            chk("flush_valid", 32'(if_id_valid), 32'h0);
            chk("flush_inst", if_id_inst, NOP);
            chk("flush_pc_hold", if_id_pc, ppc);
            exp_pc = ptgt & ~32'h3;
        end else if (ps) begin
            chk("stall_valid", 32'(if_id_valid), 32'(pv));
            chk("stall_pc", if_id_pc, ppc);
            chk("stall_pc4", if_id_pc4, ppc4);
            chk("stall_inst", if_id_inst, pinst);
        end else if (if_id_valid) begin
            chk("load_pc", if_id_pc, exp_pc);
            chk("load_pc4", if_id_pc4, exp_pc + 32'd4);
            chk("load_inst", if_id_inst, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            loaded = 1;
            nloads++;
        end else begin
            chk("bubble_inst", if_id_inst, NOP);
            chk("bubble_pc", if_id_pc, ppc);
        end
        if (last_req_v && !prdy && !pf) begin
            chk("req_hold_v", 32'(imem_req_valid), 32'h1);
            chk("req_hold_a", imem_req_addr, last_req_a);
        end
    endtask

    task automatic wait_load();
        hz_stall = 0; hz_flush = 0; imem_req_ready = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (loaded) break;
        end
        chk("wait_load", 32'(loaded), 32'h1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'h0);
        chk({tag, "_pc"}, if_id_pc, 32'h0);
        chk({tag, "_pc4"}, if_id_pc4, 32'h0);
        chk({tag, "_inst"}, if_id_inst, NOP);
        chk({tag, "_req"}, 32'(imem_req_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old, lp[$];
        int          lc[$], nl;
        hz_stall = 0; hz_flush = 0; ex_target = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        rst_n = 1; exp_pc = RPC;

        // ready low three cycles, then accepted
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rdylo_v", 32'(last_req_v), 32'h1);
            chk("rdylo_a", last_req_a, RPC);
            chk("rdylo_pend", 32'(pend), 32'h0);
        end
        imem_req_ready = 1;
        tick();
        chk("rdy_acc", 32'(pend), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (loaded) begin lc.push_back(cyc); lp.push_back(if_id_pc); end
        end
        chk("seq_n", 32'(lp.size()), 32'd4);
        if (lp.size() >= 3) begin
            chk("seq0", lp[0], 32'h100);
            chk("seq1", lp[1], 32'h104);
            chk("seq2", lp[2], 32'h108);
            chk("gap1", 32'(lc[1] - lc[0]), 32'd2);
            chk("gap2", 32'(lc[2] - lc[1]), 32'd2);
        end

        // stall while the response arrives
        wait_load();
        old = if_id_inst;
        ovr[exp_pc] = 32'h0050_0093;
        hz_stall = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_old", if_id_inst, old);
        end
        hz_stall = 0;
        tick();
        chk("stall_rel_v", 32'(if_id_valid), 32'h1);
        chk("stall_rel_i", if_id_inst, 32'h0050_0093);

        // flush while waiting: late response dropped
        wait_load();
        lat = 3;
        tick();
        hz_flush = 1; ex_target = 32'h200;
        tick();
        hz_flush = 0; lat = 1; nl = nloads;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (last_req_v) break;
        end
        chk("flush_addr", last_req_a, 32'h200);
        chk("drop_noload", 32'(nloads - nl), 32'h0);

        // flush + stall + response in one cycle
        wait_load();
        tick();
        hz_flush = 1; hz_stall = 1; ex_target = 32'h303;
        tick();
        hz_flush = 0; hz_stall = 0; lat = 3;
        tick();
        chk("fsr_v", 32'(last_req_v), 32'h1);
        chk("fsr_addr", last_req_a, 32'h300);

        // async reset while a request is outstanding
        #2 rst_n = 0;
        #1 chk_reset_outs("arst");
        pend = 0; lat = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1; exp_pc = RPC;
        tick();
        chk("arst_addr", last_req_a, RPC);

        // PC wrap through zero
        wait_load();
        hz_flush = 1; ex_target = 32'hFFFF_FFFC;
        tick();
        hz_flush = 0;
        wait_load();
        chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        wait_load();
        chk("wrap_next", if_id_pc, 32'h0);

        // random hazards and memory timing
        nl = nloads;
        for (int i = 0; i < 600; i++) begin
            hz_stall = ($urandom % 4) == 0;
            hz_flush = ($urandom % 12) == 0;
            ex_target = ($urandom % 5 == 0) ? (32'hFFFF_FFF8 | ($urandom % 4))
                                            : $urandom;
            imem_req_ready = ($urandom % 10) < 7;
            lat = $urandom_range(1, 3);
            tick();
        end
        hz_stall = 0; hz_flush = 0;
        chk("liveness", 32'(nloads - nl > 30), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
